uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter on the CPU data bus, downstream of the core's `memwrite_cs`/`memread` I/O port, in parallel with the word RAM and the LED register. CPU stores push bytes into a small FIFO. An 8N1 serializer drains the FIFO onto `o_tx` at a programmable baud divisor. Status and divisor registers are readable, so firmware can poll before each write.

## Interface
- `BASE_ADDR`, 32'h00000410: byte address of the register block. TXDATA at +0, STATUS at +4, DIVISOR at +8.
- `DIV_RESET`, 434: reset value of DIVISOR, in clock cycles per bit (50 MHz / 115200).
- `FIFO_DEPTH`, 4: TX FIFO entries, power of two, at least 2.

- `clock` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `i_write_cs` in 1: CPU store strobe, one cycle per store.
- `i_read_cs` in 1: CPU load strobe.
- `i_address` in 32: CPU byte address.
- `i_wdat` in 32: store data.
- `o_rdat` out 32: load data. Combinational. 0 when not selected.
- `o_sel` out 1: combinational. High when `i_address` hits one of the three registers, for the top-level read mux.
- `o_tx` out 1: serial output. Idles high.

## Operation
- Address decode uses a full 32-bit compare against `BASE_ADDR`, `BASE_ADDR+4` and `BASE_ADDR+8`.
- **TXDATA write:** pushes `i_wdat[7:0]`.
  - If the FIFO is full with no pop in the same cycle, the byte is dropped and sticky `ovf` is set.
  - If the FIFO is full and a pop occurs in the same cycle, the push is accepted.
- **STATUS read:** `{28'b0, ovf, busy, empty, full}`.
  - `busy` = FSM not in IDLE.
- **STATUS write:** writing 1 to bit3 clears `ovf`.
- **DIVISOR write:** stores `i_wdat[15:0]`. Stored values below 2 act as 2.
  - The divisor is latched into the active-divisor register at frame start.
  - A write mid-frame therefore affects only the next frame.
- **DIVISOR read:** `{16'b0, DIVISOR}`, returning the stored value, not the clamped one.
- **TXDATA read:** returns 0.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty. That same cycle, the FSM pops the head into the shift register and latches the divisor.
  - START → DATA after D cycles (D = latched, clamped divisor).
  - DATA shifts 8 bits LSB first, each held for D cycles. A 3-bit counter tracks the bit index.
  - DATA → STOP after bit 7.
  - STOP holds `o_tx`=1 for D cycles. It then goes to START, popping immediately, if the FIFO is non-empty; otherwise to IDLE.
- **Bit timer:** down-counter loaded with D-1 on entry to each bit. The bit ends when it reaches 0.
- **Reset values:** `o_tx`=1, FSM=IDLE, FIFO empty, `ovf`=0, DIVISOR=`DIV_RESET`, shift register 0, `o_rdat` follows its combinational rule.
- **Reset mid-frame:** the frame is abandoned, `o_tx` returns high the next cycle, and FIFO contents are discarded.

## Timing
- A store to TXDATA in cycle N with the FIFO empty and FSM in IDLE: the FIFO is written at the end of N. The FSM pops at the end of N+1. `o_tx` falls in cycle N+2.
- Full frame length: exactly 10·D cycles, start edge to end of stop bit.
- Back-to-back bytes: the next start bit begins the cycle after the last stop-bit cycle, with no idle gap.
- `empty`/`full` reflect the registered FIFO state and update the cycle after a push or pop.
- Reads have zero-cycle latency (combinational) and no side effects.

## Structure
- Shared package `riscv_io_pkg` holds:
  - register offset constants `UART_TXDATA_OFS`, `UART_STATUS_OFS` and `UART_DIV_OFS`;
  - the STATUS bit-index constants;
  - the FSM state enum `uart_state_t`.
- Sub-module `sync_fifo`, parameterised `WIDTH`=8 and `DEPTH`. Ports: push, pop, din, dout (show-ahead), full, empty. Pointer arithmetic wraps with one extra bit to distinguish full from empty.
- The top of the block holds decode, registers, FSM and bit timer.

## Test plan
- **Reset:** assert `rst` 2 cycles → `o_tx`=1, STATUS reads 32'h2, DIVISOR reads 434.
- **Single byte:** DIVISOR=4, store 8'hA5 to TXDATA → `o_tx` falls 2 cycles later and emits 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. Total 40 cycles, then `busy`=0.
- **Overflow:** DIVISOR=16, store 6 bytes on consecutive cycles → first byte goes to the shifter, 4 fill the FIFO, 6th dropped. STATUS shows `full` and `ovf`. The 5 accepted bytes serialize in order with no gaps. Writing 8 to STATUS clears `ovf`.
- **Divisor change mid-frame:** DIVISOR=4, send 8'h00, write DIVISOR=8 during bit 3, queue 8'hFF → first frame stays at 4 cycles/bit, second at 8.
- **Divisor clamp:** write DIVISOR=0 → reads back 0, bits last 2 cycles.
- **Reset mid-frame:** assert `rst` during bit 5 → `o_tx` high next cycle, STATUS=32'h2, a queued byte is not sent.

Source files
------------

// File: rtl/riscv_io_pkg.sv
// Shared definitions for the memory-mapped I/O peripherals on the CPU data bus:
// register offsets, UART status bit positions and the UART transmitter state type.
package riscv_io_pkg;

    localparam logic [31:0] UART_TXDATA_OFS = 32'h0000_0000;
    localparam logic [31:0] UART_STATUS_OFS = 32'h0000_0004;
    localparam logic [31:0] UART_DIV_OFS    = 32'h0000_0008;

    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_BUSY_BIT  = 2;
    localparam int STAT_OVF_BIT   = 3;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

    // Divisors below 2 cannot time a bit with a down-counter reload, so they act as 2.
    function automatic logic [15:0] clamp_div(input logic [15:0] div);
        if (div < 16'd2) begin
            return 16'd2;
        end else begin
            return div;
        end
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; pointers carry one extra wrap bit so full and
// empty are distinguished without a separate counter.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign dout  = mem_r[rd_ptr_r[AW-1:0]];

    // Read and write pointer advance.
    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Entry storage; contents are meaningless while empty, so no reset is needed.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, divisor and
// status registers, and the serializer FSM with its per-bit down-counter.
module uart_tx_mmio
    import riscv_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0410,
    parameter logic [15:0] DIV_RESET  = 16'd434,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        i_write_cs,
    input  logic        i_read_cs,
    input  logic [31:0] i_address,
    input  logic [31:0] i_wdat,
    output logic [31:0] o_rdat,
    output logic        o_sel,
    output logic        o_tx
);

    logic        hit_tx_s, hit_stat_s, hit_div_s;
    logic        push_s, pop_s, launch_s, busy_s;
    logic [7:0]  fifo_dout_s;
    logic        fifo_full_s, fifo_empty_s;
    logic [15:0] div_r, div_new_s;
    logic        ovf_r;
    logic [31:0] status_s;
    logic        unused_wdat_s;

    uart_state_t state_r, state_s;
    logic [15:0] timer_r, timer_s;
    logic [15:0] div_act_r, div_act_s;
    logic [2:0]  bit_cnt_r, bit_cnt_s;
    logic [7:0]  shift_r, shift_s;
    logic        tx_r, tx_s;

    assign hit_tx_s   = (i_address == BASE_ADDR + UART_TXDATA_OFS);
    assign hit_stat_s = (i_address == BASE_ADDR + UART_STATUS_OFS);
    assign hit_div_s  = (i_address == BASE_ADDR + UART_DIV_OFS);
    assign o_sel      = hit_tx_s | hit_stat_s | hit_div_s;

    assign push_s        = i_write_cs & hit_tx_s;
    assign div_new_s     = clamp_div(div_r);
    assign busy_s        = (state_r != UART_IDLE);
    assign o_tx          = tx_r;
    assign unused_wdat_s = ^i_wdat[31:16];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (i_wdat[7:0]),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Divisor register and sticky overflow flag.
    always_ff @(posedge clock) begin
        if (rst) begin
            div_r <= DIV_RESET;
            ovf_r <= 1'b0;
        end else begin
            if (i_write_cs && hit_div_s) begin
                div_r <= i_wdat[15:0];
            end
            if (push_s && fifo_full_s && !pop_s) begin
                ovf_r <= 1'b1;
            end else if (i_write_cs && hit_stat_s && i_wdat[STAT_OVF_BIT]) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Status word assembly.
    always_comb begin
        status_s = 32'd0;
        status_s[STAT_FULL_BIT]  = fifo_full_s;
        status_s[STAT_EMPTY_BIT] = fifo_empty_s;
        status_s[STAT_BUSY_BIT]  = busy_s;
        status_s[STAT_OVF_BIT]   = ovf_r;
    end

    // Load data mux; TXDATA reads back as zero.
    always_comb begin
        if (!i_read_cs) begin
            o_rdat = 32'd0;
        end else if (hit_stat_s) begin
            o_rdat = status_s;
        end else if (hit_div_s) begin
            o_rdat = {16'd0, div_r};
        end else begin
            o_rdat = 32'd0;
        end
    end

    // Serializer next-state: tx_s is the line level for the following cycle.
    always_comb begin
        state_s   = state_r;
        timer_s   = timer_r;
        bit_cnt_s = bit_cnt_r;
        shift_s   = shift_r;
        div_act_s = div_act_r;
        tx_s      = tx_r;
        launch_s  = 1'b0;
        pop_s     = 1'b0;
        case (state_r)
            UART_IDLE: begin
                if (!fifo_empty_s) begin
                    launch_s = 1'b1;
                end else begin
                    tx_s = 1'b1;
                end
            end
            UART_START: begin
                if (timer_r == 16'd0) begin
                    state_s   = UART_DATA;
                    timer_s   = div_act_r - 16'd1;
                    bit_cnt_s = 3'd0;
                    tx_s      = shift_r[0];
                end else begin
                    timer_s = timer_r - 16'd1;
                    tx_s    = 1'b0;
                end
            end
            UART_DATA: begin
                if (timer_r == 16'd0) begin
                    timer_s = div_act_r - 16'd1;
                    if (bit_cnt_r == 3'd7) begin
                        state_s = UART_STOP;
                        tx_s    = 1'b1;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                        shift_s   = {1'b0, shift_r[7:1]};
                        tx_s      = shift_r[1];
                    end
                end else begin
                    timer_s = timer_r - 16'd1;
                end
            end
            UART_STOP: begin
                if (timer_r != 16'd0) begin
                    timer_s = timer_r - 16'd1;
                    tx_s    = 1'b1;
                end else if (!fifo_empty_s) begin
                    launch_s = 1'b1;
                end else begin
                    state_s = UART_IDLE;
                    tx_s    = 1'b1;
                end
            end
            default: begin
                state_s = UART_IDLE;
                tx_s    = 1'b1;
            end
        endcase
        // Frame start: pop the head and freeze the divisor for the whole frame.
        if (launch_s) begin
            pop_s     = 1'b1;
            state_s   = UART_START;
            shift_s   = fifo_dout_s;
            div_act_s = div_new_s;
            timer_s   = div_new_s - 16'd1;
            tx_s      = 1'b0;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Serializer state registers.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_r   <= UART_IDLE;
            timer_r   <= 16'd0;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'd0;
            div_act_r <= 16'd2;
            tx_r      <= 1'b1;
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            bit_cnt_r <= bit_cnt_s;
            shift_r   <= shift_s;
            div_act_r <= div_act_s;
            tx_r      <= tx_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: a waveform-level reference model (byte queue plus a
// queue of expected line levels) checked every cycle, with directed literal pins.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE  = 32'h0000_0410;
    localparam int          DEPTH = 4;

    logic        clock = 1'b0;
    logic        rst, write_cs, read_cs;
    logic [31:0] address, wdat, rdat;
    logic        sel, tx;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_cyc = 0;

    always #5 clock = ~clock;

    uart_tx_mmio #(
        .BASE_ADDR  (BASE),
        .DIV_RESET  (16'd434),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .i_write_cs (write_cs),
        .i_read_cs  (read_cs),
        .i_address  (address),
        .i_wdat     (wdat),
        .o_rdat     (rdat),
        .o_sel      (sel),
        .o_tx       (tx)
    );

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: pending bytes, and the line levels still owed for the current frame.
    logic [7:0]  m_fifo[$];
    bit          m_wave[$];
    logic [15:0] m_div;
    bit          m_ovf;
    bit          m_valid = 1'b0;
    bit          pop_now, exp_tx, exp_sel;
    logic [7:0]  pop_byte;
    logic [9:0]  frame;
    logic [31:0] exp_rd;
    int          d_m;

    always @(negedge clock) begin
        if (m_valid) begin
            exp_tx  = (m_wave.size() > 0) ? m_wave[0] : 1'b1;
            exp_sel = (address == BASE) || (address == BASE + 32'd4) || (address == BASE + 32'd8);
            exp_rd  = 32'd0;
            if (read_cs && address == BASE + 32'd4) begin
                exp_rd[3] = m_ovf;
                exp_rd[2] = (m_wave.size() > 0);
                exp_rd[1] = (m_fifo.size() == 0);
                exp_rd[0] = (m_fifo.size() == DEPTH);
            end else if (read_cs && address == BASE + 32'd8) begin
                exp_rd = {16'd0, m_div};
            end
            check("o_tx", {31'd0, tx}, {31'd0, exp_tx});
            check("o_sel", {31'd0, sel}, {31'd0, exp_sel});
            check("o_rdat", rdat, exp_rd);
        end
        // Advance the model with the inputs that the coming rising edge will capture.
        if (rst) begin
            m_fifo.delete();
            m_wave.delete();
            m_div   = 16'd434;
            m_ovf   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            pop_now = (m_wave.size() <= 1) && (m_fifo.size() > 0);
            if (pop_now) pop_byte = m_fifo.pop_front();
            if (write_cs && address == BASE) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(wdat[7:0]);
                else m_ovf = 1'b1;
            end
            if (write_cs && address == BASE + 32'd4 && wdat[3]) m_ovf = 1'b0;
            if (m_wave.size() > 0) m_wave.delete(0);
            if (pop_now) begin
                d_m   = (m_div < 16'd2) ? 2 : int'(m_div);
                frame = {1'b1, pop_byte, 1'b0};
                for (int i = 0; i < 10; i++)
                    for (int j = 0; j < d_m; j++) m_wave.push_back(frame[i]);
            end
            if (write_cs && address == BASE + 32'd8) m_div = wdat[15:0];
        end
    end

    task automatic idle_in();
        write_cs = 1'b0;
        read_cs  = 1'b0;
        address  = 32'd0;
        wdat     = 32'd0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        write_cs = 1'b1;
        address  = a;
        wdat     = d;
        last_cyc = cyc;
        @(posedge clock);
        #1;
        idle_in();
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        read_cs = 1'b1;
        address = a;
        @(negedge clock);
        check(name, rdat, exp);
        @(posedge clock);
        #1;
        idle_in();
    endtask

    task automatic goto(input int k);
        while (cyc < k) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic tx_at(input string name, input int k, input logic exp);
        goto(k);
        @(negedge clock);
        check(name, {31'd0, tx}, {31'd0, exp});
    endtask

    logic [9:0]  pat_a5 = 10'b11_0100_1010;
    logic [31:0] addr_tab[6];
    int n, zeros, r;

    initial begin
        addr_tab = '{BASE, BASE + 32'd4, BASE + 32'd8, BASE + 32'd12, BASE + 32'd1, BASE | 32'h1000_0000};
        rst = 1'b1;
        idle_in();
        repeat (2) @(posedge clock);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clock);
        check("reset_tx", {31'd0, tx}, 32'd1);
        @(posedge clock);
        #1;
        rd_check("reset_status", BASE + 32'd4, 32'h2);
        rd_check("reset_div", BASE + 32'd8, 32'd434);
        rd_check("txdata_read", BASE, 32'd0);

        // Single byte 8'hA5 at 4 cycles per bit
        wr(BASE + 32'd8, 32'd4);
        wr(BASE, 32'h0000_00A5);
        n = last_cyc;
        tx_at("a5_before_start", n + 1, 1'b1);
        for (int k = n + 2; k < n + 42; k++) tx_at("a5_bit", k, pat_a5[(k - n - 2) / 4]);
        goto(n + 42);
        rd_check("a5_done_status", BASE + 32'd4, 32'h2);

        // Overflow: six stores back to back, the last is dropped
        wr(BASE + 32'd8, 32'd16);
        for (int i = 1; i <= 6; i++) wr(BASE, 32'h11 * i);
        rd_check("ovf_status_full", BASE + 32'd4, 32'hD);
        repeat (810) @(posedge clock);
        #1;
        rd_check("ovf_status_drained", BASE + 32'd4, 32'hA);
        wr(BASE + 32'd4, 32'd8);
        rd_check("ovf_cleared", BASE + 32'd4, 32'h2);

        // Divisor change during bit 3 only affects the next frame
        wr(BASE + 32'd8, 32'd4);
        wr(BASE, 32'h0000_0000);
        n = last_cyc;
        goto(n + 18);
        wr(BASE + 32'd8, 32'd8);
        wr(BASE, 32'h0000_00FF);
        tx_at("div_f1_bit7", n + 37, 1'b0);
        tx_at("div_f1_stop", n + 38, 1'b1);
        tx_at("div_f1_stop_end", n + 41, 1'b1);
        tx_at("div_f2_start", n + 42, 1'b0);
        tx_at("div_f2_start_end", n + 49, 1'b0);
        tx_at("div_f2_bit0", n + 50, 1'b1);
        goto(n + 122);
        rd_check("div_done_status", BASE + 32'd4, 32'h2);

        // Divisor 0 reads back 0 but times bits as 2 cycles
        wr(BASE + 32'd8, 32'd0);
        rd_check("clamp_readback", BASE + 32'd8, 32'd0);
        wr(BASE, 32'h0000_005A);
        n = last_cyc;
        tx_at("clamp_start", n + 2, 1'b0);
        tx_at("clamp_start_end", n + 3, 1'b0);
        tx_at("clamp_bit0", n + 5, 1'b0);
        tx_at("clamp_bit1", n + 6, 1'b1);
        tx_at("clamp_bit1_end", n + 7, 1'b1);
        tx_at("clamp_bit2", n + 8, 1'b0);
        goto(n + 25);

        // Reset during bit 5 abandons the frame and the queued byte
        wr(BASE + 32'd8, 32'd4);
        wr(BASE, 32'h0000_00C3);
        n = last_cyc;
        wr(BASE, 32'h0000_003C);
        goto(n + 27);
        rst = 1'b1;
        @(negedge clock);
        check("rst_mid_bit5", {31'd0, tx}, 32'd0);
        @(posedge clock);
        #1;
        rst = 1'b0;
        read_cs = 1'b1;
        address = BASE + 32'd4;
        @(negedge clock);
        check("rst_mid_tx_high", {31'd0, tx}, 32'd1);
        check("rst_mid_status", rdat, 32'h2);
        @(posedge clock);
        #1;
        idle_in();
        zeros = 0;
        repeat (80) begin
            @(negedge clock);
            if (tx == 1'b0) zeros++;
        end
        check("rst_mid_no_send", zeros, 32'd0);
        @(posedge clock);
        #1;

        // Randomized traffic against the model
        for (int it = 0; it < 3000; it++) begin
            r = $urandom_range(0, 99);
            idle_in();
            rst  = 1'b0;
            wdat = $urandom;
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
            end else if (r < 14) begin
                write_cs = 1'b1;
                address  = BASE;
            end else if (r < 17) begin
                write_cs   = 1'b1;
                address    = BASE + 32'd8;
                wdat[15:0] = 16'($urandom_range(0, 5));
            end else if (r < 20) begin
                write_cs = 1'b1;
                address  = BASE + 32'd4;
            end else if (r < 23) begin
                write_cs = 1'b1;
                address  = addr_tab[$urandom_range(3, 5)];
            end else if (r < 45) begin
                read_cs = 1'b1;
                address = addr_tab[$urandom_range(0, 5)];
            end
            @(posedge clock);
            #1;
        end
        rst = 1'b0;
        idle_in();
        repeat (5) @(posedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL timeout: simulation did not complete within 1000000 time units");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
